// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer wrap for arbitrary depths
// and the occupancy counter width.
package fifo_pkg;

  // Occupancy must represent 0..A_MAX, hence one bit more than the pointers.
  function automatic int cnt_width(input int a_width);
    return a_width + 1;
  endfunction

  // Wraps at depth-1 instead of relying on natural overflow, so depths that
  // are not a power of two work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Only the read register is reset; the array itself keeps its contents.
module fifo_mem #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 5,
  parameter int A_MAX   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [A_MAX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow and synchronous flush. All outputs are registered.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 5,
  parameter int A_MAX    = 32,
  parameter int AF_LEVEL = A_MAX - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 write_enable,
  input  logic [D_WIDTH-1:0]   data_write,
  input  logic                 read_enable,
  output logic [D_WIDTH-1:0]   data_read,
  output logic                 read_valid,
  output logic [A_WIDTH:0]     count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int C_WIDTH = cnt_width(A_WIDTH);

  logic [A_WIDTH-1:0] wr_ptr, rd_ptr;
  logic               wr_acc, rd_acc;
  logic [C_WIDTH-1:0] count_next;

  // Handshake: there is no back-pressure signal. A request is accepted in the
  // cycle it is presented if the FIFO can take it (write: not full, or a read
  // is accepted alongside; read: not empty); otherwise it is dropped and the
  // matching sticky error flag is set. flush overrides both requests.
  assign rd_acc = read_enable && !empty && !flush;
  assign wr_acc = write_enable && (!full || rd_acc) && !flush;

  always_comb begin
    count_next = count;
    if (flush)                 count_next = '0;
    else if (wr_acc && !rd_acc) count_next = count + 1'b1;
    else if (rd_acc && !wr_acc) count_next = count - 1'b1;
  end

  fifo_mem #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH),
    .A_MAX   (A_MAX)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_write),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (data_read)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      read_valid   <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_next;
      read_valid   <= rd_acc;
      // Flags follow the next count so they move on the same edge as count.
      empty        <= (count_next == '0);
      full         <= (count_next == C_WIDTH'(A_MAX));
      almost_empty <= (count_next <= C_WIDTH'(AE_LEVEL));
      almost_full  <= (count_next >= C_WIDTH'(AF_LEVEL));
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= A_WIDTH'(ptr_inc(32'(wr_ptr), A_MAX));
        if (rd_acc) rd_ptr <= A_WIDTH'(ptr_inc(32'(rd_ptr), A_MAX));
        if (write_enable && !wr_acc) overflow  <= 1'b1;
        if (read_enable && !rd_acc)  underflow <= 1'b1;
      end
    end
  end

endmodule
